// File: rtl/imem_ctrl.sv
// Instruction memory controller: a single-port word array shared by a pipelined CPU
// fetch port and a loader port whose writes are staged in a forwarding write buffer.
module imem_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int RD_LAT   = 1,
    parameter int WB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_en,
    input  logic [ADDR_W-1:0] im_add,
    output logic [DATA_W-1:0] im_data,
    output logic              im_valid,
    input  logic              ld_en,
    input  logic              ld_rd_wr,
    input  logic [ADDR_W-1:0] ld_add,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              err
);

    localparam int IDX_W = $clog2(WB_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] mem_r     [DEPTH];
    logic [ADDR_W-1:0] wb_addr_r [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_r [WB_DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [RD_LAT-1:0] f_valid_r;
    logic [DATA_W-1:0] f_data_r  [RD_LAT];

    logic [PTR_W-1:0]  count_s;
    logic [IDX_W-1:0]  head_idx_s;
    logic [IDX_W-1:0]  tail_idx_s;
    logic              full_s;
    logic              empty_s;
    logic              drain_s;
    logic              fetch_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              wr_keep_s;
    logic              oor_s;
    logic              f_hit_s;
    logic              l_hit_s;
    logic [DATA_W-1:0] f_fwd_s;
    logic [DATA_W-1:0] l_fwd_s;
    logic [DATA_W-1:0] f_rd_s;
    logic [DATA_W-1:0] l_rd_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        in_range = ((ADDR_W+1)'(a) < (ADDR_W+1)'(DEPTH));
    endfunction

    // Buffer occupancy and port arbitration: fetch owns the array, then drain, then loader read
    always_comb begin
        count_s    = tail_r - head_r;
        head_idx_s = head_r[IDX_W-1:0];
        tail_idx_s = tail_r[IDX_W-1:0];
        full_s     = (count_s == PTR_W'(WB_DEPTH));
        empty_s    = (count_s == '0);
        fetch_s    = !rst && im_en;
        drain_s    = !rst && !im_en && !empty_s;
        wr_acc_s   = !rst && ld_en && ld_rd_wr && (!full_s || drain_s);
        rd_acc_s   = !rst && ld_en && !ld_rd_wr &&
                     ((!im_en && ((count_s - PTR_W'(drain_s)) == '0)) || l_hit_s);
        wr_keep_s  = wr_acc_s && in_range(ld_add);
        oor_s      = (fetch_s && !in_range(im_add)) ||
                     ((wr_acc_s || rd_acc_s) && !in_range(ld_add));
        ld_ready   = wr_acc_s || rd_acc_s;
    end

    // Youngest-match forwarding: walk oldest to youngest so the last hit wins
    always_comb begin
        f_hit_s = 1'b0;
        f_fwd_s = '0;
        l_hit_s = 1'b0;
        l_fwd_s = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            logic [IDX_W-1:0] k;
            logic             live;
            logic             f_m;
            logic             l_m;
            k       = IDX_W'(head_r + PTR_W'(i));
            live    = (PTR_W'(i) < count_s);
            f_m     = live && (wb_addr_r[k] == im_add);
            l_m     = live && (wb_addr_r[k] == ld_add);
            f_hit_s = f_hit_s | f_m;
            l_hit_s = l_hit_s | l_m;
            f_fwd_s = f_m ? wb_data_r[k] : f_fwd_s;
            l_fwd_s = l_m ? wb_data_r[k] : l_fwd_s;
        end
    end

    // Read data selection: out-of-range reads return zero
    always_comb begin
        f_rd_s = '0;
        l_rd_s = '0;
        if (!in_range(im_add)) begin
            f_rd_s = '0;
        end else if (f_hit_s) begin
            f_rd_s = f_fwd_s;
        end else begin
            f_rd_s = mem_r[im_add];
        end
        if (!in_range(ld_add)) begin
            l_rd_s = '0;
        end else if (l_hit_s) begin
            l_rd_s = l_fwd_s;
        end else begin
            l_rd_s = mem_r[ld_add];
        end
    end

    // Write buffer pointers; out-of-range writes are acknowledged but never enqueued
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            head_r <= head_r + PTR_W'(drain_s);
            tail_r <= tail_r + PTR_W'(wr_keep_s);
        end
    end

    // Write buffer slot storage
    always_ff @(posedge clk) begin
        if (wr_keep_s) begin
            wb_addr_r[tail_idx_s] <= ld_add;
            wb_data_r[tail_idx_s] <= ld_wdata;
        end
    end

    // Array write from buffer head; the array is deliberately not reset
    always_ff @(posedge clk) begin
        if (drain_s) begin
            mem_r[wb_addr_r[head_idx_s]] <= wb_data_r[head_idx_s];
        end
    end

    // Fetch pipeline: stage 0 captures the read, later stages only add latency
    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                f_data_r[i] <= '0;
            end
        end else begin
            f_valid_r[0] <= fetch_s;
            f_data_r[0]  <= fetch_s ? f_rd_s : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                f_valid_r[i] <= f_valid_r[i-1];
                f_data_r[i]  <= f_data_r[i-1];
            end
        end
    end

    assign im_valid = f_valid_r[RD_LAT-1];
    assign im_data  = f_data_r[RD_LAT-1];

    // Loader read response and sticky range error
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            ld_rvalid <= rd_acc_s;
            ld_rdata  <= rd_acc_s ? l_rd_s : '0;
            err       <= err | oor_s;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: two instances (RD_LAT 3 and 2, DEPTH 200) share stimulus and are
// checked against an architectural memory model through per-port scoreboards.
module tb_imem_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        im_en = 1'b0;
    logic [7:0]  im_add = 8'd0;
    logic        ld_en = 1'b0;
    logic        ld_rd_wr = 1'b0;
    logic [7:0]  ld_add = 8'd0;
    logic [31:0] ld_wdata = 32'd0;
    logic [31:0] im_data_a, im_data_b, ld_rdata_a, ld_rdata_b;
    logic        im_valid_a, im_valid_b, ld_ready_a, ld_ready_b;
    logic        ld_rvalid_a, ld_rvalid_b, err_a, err_b;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit [31:0]   ref_mem [256];
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ql[$];

    imem_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .RD_LAT(3), .WB_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .im_en(im_en), .im_add(im_add), .im_data(im_data_a),
        .im_valid(im_valid_a), .ld_en(ld_en), .ld_rd_wr(ld_rd_wr), .ld_add(ld_add),
        .ld_wdata(ld_wdata), .ld_ready(ld_ready_a), .ld_rdata(ld_rdata_a),
        .ld_rvalid(ld_rvalid_a), .err(err_a));

    imem_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .RD_LAT(2), .WB_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .im_en(im_en), .im_add(im_add), .im_data(im_data_b),
        .im_valid(im_valid_b), .ld_en(ld_en), .ld_rd_wr(ld_rd_wr), .ld_add(ld_add),
        .ld_wdata(ld_wdata), .ld_ready(ld_ready_b), .ld_rdata(ld_rdata_b),
        .ld_rvalid(ld_rvalid_b), .err(err_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_rd(input logic [7:0] a);
        return (a < 8'd200) ? ref_mem[a] : 32'd0;
    endfunction

    // Scoreboard: pop and compare whenever a DUT presents a result
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL fetch_a_missing: no im_valid at cycle %0d, required data %h", qa[0].cyc, qa[0].data);
            void'(qa.pop_front());
        end
        if (im_valid_a === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++; $display("FAIL fetch_a_spurious: im_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = qa.pop_front();
                if (e.cyc != cyc || im_data_a !== e.data) begin
                    errors++;
                    $display("FAIL fetch_a_data: got %h at cycle %0d, required %h at cycle %0d", im_data_a, cyc, e.data, e.cyc);
                end
            end
        end
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL fetch_b_missing: no im_valid at cycle %0d, required data %h", qb[0].cyc, qb[0].data);
            void'(qb.pop_front());
        end
        if (im_valid_b === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++; $display("FAIL fetch_b_spurious: im_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = qb.pop_front();
                if (e.cyc != cyc || im_data_b !== e.data) begin
                    errors++;
                    $display("FAIL fetch_b_data: got %h at cycle %0d, required %h at cycle %0d", im_data_b, cyc, e.data, e.cyc);
                end
            end
        end
        if (ql.size() > 0 && ql[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL ld_rd_missing: no ld_rvalid at cycle %0d, required data %h", ql[0].cyc, ql[0].data);
            void'(ql.pop_front());
        end
        if (ld_rvalid_a === 1'b1 || ld_rvalid_b === 1'b1) begin
            checks++;
            if (ql.size() == 0) begin
                errors++; $display("FAIL ld_rd_spurious: ld_rvalid=1 at cycle %0d, required 0", cyc);
            end else begin
                e = ql.pop_front();
                if (e.cyc != cyc || ld_rdata_a !== e.data || ld_rdata_b !== e.data || ld_rvalid_a !== ld_rvalid_b) begin
                    errors++;
                    $display("FAIL ld_rd_data: got %h/%h at cycle %0d, required %h at cycle %0d", ld_rdata_a, ld_rdata_b, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // One clock of stimulus; acc is the bench's own expectation of loader acceptance
    task automatic step(input logic r, input logic fe, input logic [7:0] fa, input logic le,
                        input logic lw, input logic [7:0] la, input logic [31:0] wd,
                        input logic acc, output logic rdy);
        exp_t e;
        rst = r; im_en = fe; im_add = fa; ld_en = le; ld_rd_wr = lw; ld_add = la; ld_wdata = wd;
        #1;
        rdy = ld_ready_a;
        if (r) begin
            while (qa.size() > 0 && qa[qa.size()-1].cyc > cyc) void'(qa.pop_back());
            while (qb.size() > 0 && qb[qb.size()-1].cyc > cyc) void'(qb.pop_back());
            while (ql.size() > 0 && ql[ql.size()-1].cyc > cyc) void'(ql.pop_back());
        end else begin
            if (fe) begin
                e.data = model_rd(fa);
                e.cyc = cyc + 3; qa.push_back(e);
                e.cyc = cyc + 2; qb.push_back(e);
            end
            if (le && acc && lw && la < 8'd200) ref_mem[la] = wd;
            if (le && acc && !lw) begin
                e.data = model_rd(la); e.cyc = cyc + 1; ql.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic r;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, r);
    endtask

    task automatic test_reset;
        logic rdy;
        step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 32'h1234_5678, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", rdy); end
        step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 32'h1234_5678, 1'b0, rdy);
        checks++;
        if ({im_valid_a, im_valid_b, ld_rvalid_a, ld_rvalid_b, err_a, err_b} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 000000",
                {im_valid_a, im_valid_b, ld_rvalid_a, ld_rvalid_b, err_a, err_b});
        end
        checks++;
        if ({im_data_a, ld_rdata_a} !== 64'd0) begin
            errors++; $display("FAIL reset_data: got %h required 0", {im_data_a, ld_rdata_a});
        end
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 32'hDEAD_BEEF, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL first_after_reset: got ld_ready=%b required 1", rdy); end
    endtask

    task automatic test_fetch_latency;
        logic rdy;
        idle(5);
        step(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (im_valid_a !== (k == 3) || im_valid_b !== (k == 2)) begin
                errors++; $display("FAIL fetch_latency: T+%0d got valid a/b=%b/%b required %b/%b",
                    k, im_valid_a, im_valid_b, (k == 3), (k == 2));
            end
            if (k == 3) begin
                checks++;
                if (im_data_a !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL fetch_latency_data: got %h required deadbeef", im_data_a);
                end
            end
            idle(1);
        end
    endtask

    task automatic test_wb_full;
        logic rdy;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 8'(20 + i), 32'hA000_0000 + i, (i < 4), rdy);
            checks++;
            if (rdy !== (i < 4)) begin errors++; $display("FAIL wb_full_ready[%0d]: got %b required %b", i, rdy, (i < 4)); end
        end
        idle(4);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd24, 32'hA000_0004, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL wb_after_drain: got %b required 1", rdy); end
        idle(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 8'(40 + i), 32'hB000_0000 + i, 1'b1, rdy);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd44, 32'hB000_0004, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL wb_full_with_drain: got %b required 1", rdy); end
        idle(6);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'(20 + i), 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
            step(1'b0, 1'b1, 8'(40 + i), 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
        end
        idle(4);
    endtask

    task automatic test_forward;
        logic rdy;
        step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 8'd9, 32'h11, 1'b1, rdy);
        step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 8'd9, 32'h22, 1'b1, rdy);
        step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
        step(1'b0, 1'b1, 8'd9, 1'b1, 1'b0, 8'd9, 32'd0, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL ld_rd_hit_ready: got %b required 1", rdy); end
        step(1'b0, 1'b1, 8'd9, 1'b1, 1'b0, 8'd5, 32'd0, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL ld_rd_miss_fetch: got %b required 0", rdy); end
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 32'd0, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL ld_rd_miss_busy: got %b required 0", rdy); end
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd5, 32'd0, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL ld_rd_last_drain: got %b required 1", rdy); end
        idle(2);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 32'd0, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL ld_rd_empty: got %b required 1", rdy); end
        step(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
        idle(4);
    endtask

    task automatic test_oor;
        logic rdy;
        checks++;
        if (err_a !== 1'b0) begin errors++; $display("FAIL err_before: got %b required 0", err_a); end
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd210, 32'h55, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1 || err_a !== 1'b1 || err_b !== 1'b1) begin
            errors++; $display("FAIL oor_write: got ready=%b err=%b/%b required 1 1/1", rdy, err_a, err_b);
        end
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd210, 32'd0, 1'b1, rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL oor_read_ready: got %b required 1", rdy); end
        step(1'b0, 1'b1, 8'd210, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
        idle(5);
        checks++;
        if (err_a !== 1'b1 || err_b !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b/%b required 1/1", err_a, err_b); end
    endtask

    task automatic test_reset_mid;
        logic rdy;
        logic [31:0] old [3];
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'(30 + i), 32'hB0 + i, 1'b1, rdy);
        idle(4);
        for (int i = 0; i < 3; i++) old[i] = ref_mem[30 + i];
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 8'(30 + i), 32'hC0 + i, 1'b1, rdy);
        step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'd33, 32'hC3, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b required 0", rdy); end
        checks++;
        if ({im_valid_a, im_valid_b, ld_rvalid_a, err_a, err_b} !== 5'b0 || im_data_a !== 32'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got %b data %h required 00000 data 0",
                {im_valid_a, im_valid_b, ld_rvalid_a, err_a, err_b}, im_data_a);
        end
        for (int i = 0; i < 3; i++) ref_mem[30 + i] = old[i];
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(30 + i), 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
        idle(4);
    endtask

    task automatic test_back_to_back;
        logic rdy;
        int   run;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'(i), 32'h1000 + i, 1'b1, rdy);
        idle(3);
        run = 0;
        for (int j = 0; j < 18; j++) begin
            step(1'b0, (j < 16), (j < 16) ? 8'(j) : 8'd0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, rdy);
            checks++;
            if (im_valid_b !== (j >= 1 && j <= 16)) begin
                errors++; $display("FAIL b2b_valid[%0d]: got %b required %b", j, im_valid_b, (j >= 1 && j <= 16));
            end else if (im_valid_b === 1'b1 && im_data_b !== 32'h1000 + (j - 1)) begin
                errors++; $display("FAIL b2b_data[%0d]: got %h required %h", j, im_data_b, 32'h1000 + (j - 1));
            end
            run = (im_valid_b === 1'b1) ? run + 1 : run;
        end
        checks++;
        if (run != 16) begin errors++; $display("FAIL b2b_run: got %0d valid cycles required 16", run); end
    endtask

    task automatic test_drained;
        idle(6);
        checks++;
        if (qa.size() != 0 || qb.size() != 0 || ql.size() != 0) begin
            errors++; $display("FAIL outstanding: got %0d/%0d/%0d pending results required 0/0/0", qa.size(), qb.size(), ql.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch_latency();
        test_wb_full();
        test_forward();
        test_oor();
        test_reset_mid();
        test_back_to_back();
        test_drained();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, address width in words.
REQ-002 The block SHALL take parameter DATA_W, default 32, word width.
REQ-003 The block SHALL take parameter DEPTH, default 256, implemented words, DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL take parameter RD_LAT, default 1, legal 1..4, fetch read latency in cycles.
REQ-005 The block SHALL take parameter WB_DEPTH, default 4, power of two >= 2, write-buffer entries.
REQ-006 The block SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port im_en, input, 1, CPU fetch request this cycle.
REQ-009 The block SHALL have port im_add, input, ADDR_W, CPU fetch word address.
REQ-010 The block SHALL have port im_data, output, DATA_W, fetched word.
REQ-011 The block SHALL have port im_valid, output, 1, im_data valid this cycle.
REQ-012 The block SHALL have port ld_en, input, 1, loader request.
REQ-013 The block SHALL have port ld_rd_wr, input, 1, loader direction, 1 = write, 0 = read.
REQ-014 The block SHALL have port ld_add, input, ADDR_W, loader word address.
REQ-015 The block SHALL have port ld_wdata, input, DATA_W, loader write data.
REQ-016 The block SHALL have port ld_ready, output, 1, loader request accepted this cycle.
REQ-017 The block SHALL have port ld_rdata, output, DATA_W, loader read data.
REQ-018 The block SHALL have port ld_rvalid, output, 1, ld_rdata valid this cycle.
REQ-019 The block SHALL have port err, output, 1, sticky out-of-range flag.

Function
REQ-020 The array SHALL be single-port, one access per cycle; priority fetch read > buffer drain write > loader read.
REQ-021 A fetch with im_en=1 SHALL always be accepted; im_valid SHALL rise exactly RD_LAT cycles later with the data, fully pipelined, one result per cycle.
REQ-022 A loader write SHALL be accepted (ld_ready=1) iff the write buffer is not full, including a same-cycle drain freeing a slot; it SHALL enter the buffer tail that cycle.
REQ-023 The buffer head SHALL drain to the array in any cycle with im_en=0 and buffer non-empty; the entry leaves the buffer at that edge.
REQ-024 A loader read SHALL be accepted iff im_en=0 and the buffer is empty after this cycle's drain, or its address hits in the buffer; ld_rvalid SHALL rise 1 cycle after acceptance.
REQ-025 Fetch and loader reads SHALL forward from the youngest matching buffer entry in preference to the array; a write accepted in cycle N SHALL be visible to reads issued in cycle N+1.
REQ-026 Two buffered writes to one address SHALL both drain in order; the later value SHALL persist.
REQ-027 An access with address >= DEPTH SHALL return all-zero data with normal valid timing, discard any write, and set err; err SHALL clear only on rst.
REQ-028 Buffer pointers SHALL be log2(WB_DEPTH)+1 bits, wrapping modulo 2*WB_DEPTH; full = tail-head == WB_DEPTH.
REQ-029 With im_en held 1 continuously, the buffer SHALL not drain and ld_ready for writes SHALL drop once full; no entry SHALL be lost.

Reset
REQ-030 While rst=1: im_valid, ld_rvalid, ld_ready, err, im_data, ld_rdata SHALL be 0; the buffer SHALL be emptied and the fetch pipeline flushed.
REQ-031 Reset mid-operation SHALL discard undrained writes and in-flight reads; array contents SHALL be retained, not cleared.
REQ-032 The first request SHALL be accepted in the first cycle after rst falls.

Verification
REQ-033 RD_LAT=3: write 0xDEADBEEF to addr 5, idle 5 cycles, fetch addr 5 at cycle T -> im_valid=1 with 0xDEADBEEF at T+3, only then.
REQ-034 Hold im_en=1, issue 5 writes at WB_DEPTH=4 -> ld_ready=1 for the first 4, 0 on the 5th; drop im_en -> 4 drains in 4 cycles, then 5th accepted.
REQ-035 Write 0x11 then 0x22 to addr 9 under im_en=1, fetch addr 9 next cycle -> 0x22 forwarded; after drain, array read of addr 9 -> 0x22.
REQ-036 DEPTH=200: write 0x55 to addr 210 then read addr 210 -> data 0, err=1, stays 1 until rst.
REQ-037 Fill buffer with 3 writes, assert rst 1 cycle -> outputs 0; fetch of those addresses returns pre-write array values.
REQ-038 Back-to-back fetches at addr 0..15 at RD_LAT=2 -> 16 consecutive im_valid cycles, in address order.
